// File: rtl/exe_stage.sv
// ---------------------------------------------------------------------------
// exe_stage : execute stage of the in-order pipeline.
//
// Latches one issued instruction from the decode/issue stage, evaluates the
// one-hot ALU operation on it, and (for loads/stores) drives a single
// data-RAM request through a req/addr_ok handshake. The instruction is held
// until its request has been accepted and MEM can take it, then the result is
// handed to MEM. The stage also reports its destination register and result
// back to issue for bypassing / wake-up.
//
// Ports
//   clk                in   clock
//   reset              in   asynchronous reset, active low (0 = reset)
//   ID_to_EXE_bus      in   153b {stage_valid[2:0], rf_w_en, rf_w_data_sel,
//                           ram_wd, ram_we, ram_en, ram_wdata[31:0],
//                           w_addr[4:0], alu_op[11:0], src2[31:0],
//                           src1[31:0], inst_PC[31:0]}
//   ID_to_EXE_valid    in   issue bus valid
//   EXE_allow_in       out  stage can accept a new instruction this cycle
//   MEM_allow_in       in   MEM stage can accept
//   EXE_to_MEM_valid   out  EXE_to_MEM_bus valid
//   EXE_to_MEM_bus     out  74b {stage_valid[2:0], rf_w_en, rf_w_data_sel,
//                           w_addr[4:0], alu_result[31:0], inst_PC[31:0]}
//   EXE_to_BY_bus      out  40b {w_addr[4:0], alu_result[31:0], data_valid,
//                           EXE_valid, rf_w_en}
//   data_sram_req      out  memory request
//   data_sram_wr       out  1 = store
//   data_sram_wstrb    out  byte strobes
//   data_sram_addr     out  request address (= alu_result)
//   data_sram_wdata    out  store data
//   data_sram_addr_ok  in   request accepted this cycle
// ---------------------------------------------------------------------------
module exe_stage #(
    parameter int ID_TO_EXE_BUS_WD  = 153,
    parameter int EXE_TO_MEM_BUS_WD = 74,
    parameter int EXE_TO_BY_BUS_WD  = 40
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ID_TO_EXE_BUS_WD-1:0]  ID_to_EXE_bus,
    input  logic                         ID_to_EXE_valid,
    output logic                         EXE_allow_in,
    input  logic                         MEM_allow_in,
    output logic                         EXE_to_MEM_valid,
    output logic [EXE_TO_MEM_BUS_WD-1:0] EXE_to_MEM_bus,
    output logic [EXE_TO_BY_BUS_WD-1:0]  EXE_to_BY_bus,
    output logic                         data_sram_req,
    output logic                         data_sram_wr,
    output logic [3:0]                   data_sram_wstrb,
    output logic [31:0]                  data_sram_addr,
    output logic [31:0]                  data_sram_wdata,
    input  logic                         data_sram_addr_ok
);

    // Bit position of ram_en inside the incoming issue bus; needed before the
    // instruction is latched so the FSM can go straight to REQ.
    localparam int IN_RAM_EN_BIT = 145;

    // One-hot ALU operation bit assignments.
    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SLT  = 2;
    localparam int OP_SLTU = 3;
    localparam int OP_AND  = 4;
    localparam int OP_NOR  = 5;
    localparam int OP_OR   = 6;
    localparam int OP_XOR  = 7;
    localparam int OP_SLL  = 8;
    localparam int OP_SRL  = 9;
    localparam int OP_SRA  = 10;
    localparam int OP_LUI  = 11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Stage registers
    // -----------------------------------------------------------------------
    logic                        exe_valid_q;
    logic                        exe_valid_d;
    logic [ID_TO_EXE_BUS_WD-1:0] bus_q;
    logic [ID_TO_EXE_BUS_WD-1:0] bus_d;
    state_t                      state_q;
    state_t                      state_d;

    // Decoded fields of the latched instruction.
    logic [2:0]  stage_valid;
    logic        rf_w_en;
    logic        rf_w_data_sel;
    logic        ram_wd;
    logic        ram_we;
    logic        ram_en;
    logic [31:0] ram_wdata;
    logic [4:0]  w_addr;
    logic [11:0] alu_op;
    logic [31:0] src2;
    logic [31:0] src1;
    logic [31:0] inst_pc;

    assign {stage_valid, rf_w_en, rf_w_data_sel, ram_wd, ram_we, ram_en,
            ram_wdata, w_addr, alu_op, src2, src1, inst_pc} = bus_q;

    // ram_wd is carried on the issue bus but has no consumer in this stage.
    logic unused_ram_wd;
    assign unused_ram_wd = ram_wd;

    // Handshake / control terms.
    logic ready_go;
    logic in_mem_op;
    logic is_req;
    logic is_done;

    // -----------------------------------------------------------------------
    // ALU
    // -----------------------------------------------------------------------
    logic signed [31:0] src1_s;
    logic signed [31:0] src2_s;
    logic [4:0]         shamt;
    logic [31:0]        add_res;
    logic [31:0]        sub_res;
    logic [31:0]        slt_res;
    logic [31:0]        sltu_res;
    logic [31:0]        sll_res;
    logic [31:0]        srl_res;
    logic [31:0]        sra_res;
    logic [31:0]        alu_result;

    assign src1_s = src1;
    assign src2_s = src2;
    // Shifts take the value from src2 and the amount from src1.
    assign shamt  = src1[4:0];

    always_comb begin
        add_res  = src1 + src2;
        sub_res  = src1 - src2;
        slt_res  = {31'd0, (src1_s < src2_s)};
        sltu_res = {31'd0, (src1 < src2)};
        sll_res  = src2 << shamt;
        srl_res  = src2 >> shamt;
        sra_res  = src2_s >>> shamt;
    end

    // AND-OR select: an all-zero alu_op naturally yields zero.
    always_comb begin
        alu_result = 32'd0;
        alu_result = alu_result | ({32{alu_op[OP_ADD]}}  & add_res);
        alu_result = alu_result | ({32{alu_op[OP_SUB]}}  & sub_res);
        alu_result = alu_result | ({32{alu_op[OP_SLT]}}  & slt_res);
        alu_result = alu_result | ({32{alu_op[OP_SLTU]}} & sltu_res);
        alu_result = alu_result | ({32{alu_op[OP_AND]}}  & (src1 & src2));
        alu_result = alu_result | ({32{alu_op[OP_NOR]}}  & ~(src1 | src2));
        alu_result = alu_result | ({32{alu_op[OP_OR]}}   & (src1 | src2));
        alu_result = alu_result | ({32{alu_op[OP_XOR]}}  & (src1 ^ src2));
        alu_result = alu_result | ({32{alu_op[OP_SLL]}}  & sll_res);
        alu_result = alu_result | ({32{alu_op[OP_SRL]}}  & srl_res);
        alu_result = alu_result | ({32{alu_op[OP_SRA]}}  & sra_res);
        alu_result = alu_result | ({32{alu_op[OP_LUI]}}  & src2);
    end

    // -----------------------------------------------------------------------
    // Pipeline handshake
    // -----------------------------------------------------------------------
    assign is_req  = (state_q == S_REQ);
    assign is_done = (state_q == S_DONE);

    // A memory op is finished once its request has been accepted, either in
    // this cycle (REQ with addr_ok) or earlier (DONE).
    assign ready_go     = ~ram_en | (is_req & data_sram_addr_ok) | is_done;
    assign EXE_allow_in = ~exe_valid_q | (ready_go & MEM_allow_in);

    assign in_mem_op = ID_to_EXE_valid & ID_to_EXE_bus[IN_RAM_EN_BIT];

    always_comb begin
        exe_valid_d = exe_valid_q;
        bus_d       = bus_q;
        if (EXE_allow_in) begin
            exe_valid_d = ID_to_EXE_valid;
            // Keep the old contents on a bubble so outputs stay quiet.
            if (ID_to_EXE_valid) begin
                bus_d = ID_to_EXE_bus;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exe_valid_q <= 1'b0;
            bus_q       <= '0;
        end else begin
            exe_valid_q <= exe_valid_d;
            bus_q       <= bus_d;
        end
    end

    // -----------------------------------------------------------------------
    // Memory-request FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Memory-request FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (EXE_allow_in) begin
            // Any accept edge (including the hand-off edge of a finished
            // memory op) starts the next instruction afresh; a bubble or a
            // non-memory op parks the FSM in IDLE.
            state_d = in_mem_op ? S_REQ : S_IDLE;
        end else begin
            case (state_q)
                S_REQ: begin
                    // Accepted but MEM is stalled: remember the acceptance so
                    // the request is never repeated for this instruction.
                    if (data_sram_addr_ok) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Memory-request FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        data_sram_req   = exe_valid_q & ram_en & is_req;
        data_sram_wr    = ram_we;
        data_sram_wstrb = ram_we ? 4'hF : 4'h0;
        // The request fields come straight from the held instruction, so they
        // stay stable for as long as the request waits for addr_ok.
        data_sram_addr  = alu_result;
        data_sram_wdata = ram_wdata;
    end

    // -----------------------------------------------------------------------
    // Downstream and bypass buses
    // -----------------------------------------------------------------------
    logic data_valid;

    // Only results marked final in EXE may be forwarded; loads report 0 so
    // that issue stalls their consumers.
    assign data_valid = stage_valid[0];

    assign EXE_to_MEM_valid = exe_valid_q & ready_go;
    assign EXE_to_MEM_bus   = {stage_valid, rf_w_en, rf_w_data_sel, w_addr,
                               alu_result, inst_pc};
    assign EXE_to_BY_bus    = {w_addr, alu_result, data_valid, exe_valid_q,
                               rf_w_en};

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

    logic         clk;
    logic         reset;
    logic [152:0] ID_to_EXE_bus;
    logic         ID_to_EXE_valid;
    logic         EXE_allow_in;
    logic         MEM_allow_in;
    logic         EXE_to_MEM_valid;
    logic [73:0]  EXE_to_MEM_bus;
    logic [39:0]  EXE_to_BY_bus;
    logic         data_sram_req;
    logic         data_sram_wr;
    logic [3:0]   data_sram_wstrb;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         data_sram_addr_ok;

    int tests;
    int fails;

    exe_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ID_to_EXE_bus     (ID_to_EXE_bus),
        .ID_to_EXE_valid   (ID_to_EXE_valid),
        .EXE_allow_in      (EXE_allow_in),
        .MEM_allow_in      (MEM_allow_in),
        .EXE_to_MEM_valid  (EXE_to_MEM_valid),
        .EXE_to_MEM_bus    (EXE_to_MEM_bus),
        .EXE_to_BY_bus     (EXE_to_BY_bus),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [152:0] mk_bus(
        input logic [2:0]  sv,
        input logic        wen,
        input logic        we,
        input logic        en,
        input logic [31:0] wdata,
        input logic [4:0]  wa,
        input logic [11:0] op,
        input logic [31:0] s2,
        input logic [31:0] s1,
        input logic [31:0] pc
    );
        return {sv, wen, 1'b0, 1'b0, we, en, wdata, wa, op, s2, s1, pc};
    endfunction

    task automatic test_reset;
        ID_to_EXE_valid   = 1'b1;
        ID_to_EXE_bus     = mk_bus(3'b001, 1'b1, 1'b1, 1'b1, 32'h1234_5678,
                                   5'd4, 12'h001, 32'd1, 32'd2, 32'h40);
        #3;
        tests++; if (EXE_allow_in !== 1'b1) begin fails++; $display("FAIL reset_allow_in: got %b expected 1", EXE_allow_in); end
        tests++; if (EXE_to_MEM_valid !== 1'b0) begin fails++; $display("FAIL reset_mem_valid: got %b expected 0", EXE_to_MEM_valid); end
        tests++; if (EXE_to_MEM_bus !== 74'd0) begin fails++; $display("FAIL reset_mem_bus: got %h expected 0", EXE_to_MEM_bus); end
        tests++; if (EXE_to_BY_bus !== 40'd0) begin fails++; $display("FAIL reset_by_bus: got %h expected 0", EXE_to_BY_bus); end
        tests++; if (data_sram_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b expected 0", data_sram_req); end
        tests++; if ({data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata} !== 69'd0) begin
            fails++; $display("FAIL reset_sram_fields: got wr=%b wstrb=%h addr=%h wdata=%h expected all 0",
                              data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata);
        end
        // Edges under reset must not load anything.
        @(posedge clk); #1;
        tests++; if (EXE_to_BY_bus !== 40'd0) begin fails++; $display("FAIL reset_hold_by_bus: got %h expected 0", EXE_to_BY_bus); end
        ID_to_EXE_valid = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        tests++; if (EXE_allow_in !== 1'b1) begin fails++; $display("FAIL post_reset_allow_in: got %b expected 1", EXE_allow_in); end
        tests++; if (EXE_to_MEM_valid !== 1'b0) begin fails++; $display("FAIL post_reset_mem_valid: got %b expected 0", EXE_to_MEM_valid); end
    endtask

    task automatic test_alu;
        logic [31:0] exp_res [0:12];
        logic [11:0] op;
        logic [31:0] pc;
        // src1 = 5, src2 = 32'hFFFF_FFF0
        exp_res[0]  = 32'hFFFF_FFF5; // add
        exp_res[1]  = 32'h0000_0015; // sub: 5 - (-16)
        exp_res[2]  = 32'h0000_0000; // slt: 5 < -16 is false
        exp_res[3]  = 32'h0000_0001; // sltu
        exp_res[4]  = 32'h0000_0000; // and
        exp_res[5]  = 32'h0000_000A; // nor
        exp_res[6]  = 32'hFFFF_FFF5; // or
        exp_res[7]  = 32'hFFFF_FFF5; // xor
        exp_res[8]  = 32'hFFFF_FE00; // sll by 5
        exp_res[9]  = 32'h07FF_FFFF; // srl by 5
        exp_res[10] = 32'hFFFF_FFFF; // sra by 5
        exp_res[11] = 32'hFFFF_FFF0; // lui
        exp_res[12] = 32'h0000_0000; // no op selected
        MEM_allow_in      = 1'b1;
        data_sram_addr_ok = 1'b0;
        for (int i = 0; i < 13; i++) begin
            op = (i < 12) ? (12'd1 << i) : 12'd0;
            pc = 32'h100 + 32'(4 * i);
            ID_to_EXE_bus   = mk_bus(3'b001, 1'b1, 1'b0, 1'b0, 32'd0, 5'd1, op,
                                     32'hFFFF_FFF0, 32'd5, pc);
            ID_to_EXE_valid = 1'b1;
            @(posedge clk); #1;
            tests++; if (EXE_to_MEM_valid !== 1'b1) begin fails++; $display("FAIL alu_valid op%0d: got %b expected 1", i, EXE_to_MEM_valid); end
            tests++; if (EXE_to_MEM_bus[63:32] !== exp_res[i]) begin fails++; $display("FAIL alu_result op%0d: got %h expected %h", i, EXE_to_MEM_bus[63:32], exp_res[i]); end
            tests++; if (EXE_to_MEM_bus[31:0] !== pc) begin fails++; $display("FAIL alu_pc op%0d: got %h expected %h", i, EXE_to_MEM_bus[31:0], pc); end
        end
        ID_to_EXE_valid = 1'b0;
        @(posedge clk); #1;
        tests++; if (EXE_to_MEM_valid !== 1'b0) begin fails++; $display("FAIL alu_drain_valid: got %b expected 0", EXE_to_MEM_valid); end
    endtask

    task automatic test_store_late;
        MEM_allow_in      = 1'b1;
        data_sram_addr_ok = 1'b0;
        ID_to_EXE_bus     = mk_bus(3'b100, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 5'd0,
                                   12'h001, 32'd4, 32'h1000, 32'h200);
        ID_to_EXE_valid   = 1'b1;
        @(posedge clk); #1;
        ID_to_EXE_valid   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tests++; if (data_sram_req !== 1'b1) begin fails++; $display("FAIL store_req wait%0d: got %b expected 1", k, data_sram_req); end
            tests++; if (data_sram_addr !== 32'h1004) begin fails++; $display("FAIL store_addr wait%0d: got %h expected 00001004", k, data_sram_addr); end
            tests++; if (data_sram_wstrb !== 4'hF || data_sram_wr !== 1'b1) begin fails++; $display("FAIL store_wstrb wait%0d: got wstrb=%h wr=%b expected f/1", k, data_sram_wstrb, data_sram_wr); end
            tests++; if (data_sram_wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL store_wdata wait%0d: got %h expected deadbeef", k, data_sram_wdata); end
            tests++; if (EXE_allow_in !== 1'b0) begin fails++; $display("FAIL store_allow_in wait%0d: got %b expected 0", k, EXE_allow_in); end
            tests++; if (EXE_to_MEM_valid !== 1'b0) begin fails++; $display("FAIL store_mem_valid wait%0d: got %b expected 0", k, EXE_to_MEM_valid); end
            @(posedge clk); #1;
        end
        data_sram_addr_ok = 1'b1;
        #1;
        tests++; if (EXE_to_MEM_valid !== 1'b1) begin fails++; $display("FAIL store_ack_mem_valid: got %b expected 1", EXE_to_MEM_valid); end
        tests++; if (EXE_allow_in !== 1'b1) begin fails++; $display("FAIL store_ack_allow_in: got %b expected 1", EXE_allow_in); end
        tests++; if (EXE_to_MEM_bus[63:32] !== 32'h1004) begin fails++; $display("FAIL store_ack_result: got %h expected 00001004", EXE_to_MEM_bus[63:32]); end
        @(posedge clk); #1;
        data_sram_addr_ok = 1'b0;
        tests++; if (EXE_to_MEM_valid !== 1'b0) begin fails++; $display("FAIL store_after_mem_valid: got %b expected 0", EXE_to_MEM_valid); end
        tests++; if (data_sram_req !== 1'b0) begin fails++; $display("FAIL store_after_req: got %b expected 0", data_sram_req); end
    endtask

    task automatic test_blocked_by_mem;
        MEM_allow_in      = 1'b0;
        data_sram_addr_ok = 1'b0;
        ID_to_EXE_bus     = mk_bus(3'b010, 1'b1, 1'b0, 1'b1, 32'd0, 5'd9,
                                   12'h001, 32'h10, 32'h2000, 32'h300);
        ID_to_EXE_valid   = 1'b1;
        @(posedge clk); #1;
        ID_to_EXE_valid   = 1'b0;
        tests++; if (data_sram_req !== 1'b1) begin fails++; $display("FAIL blk_req: got %b expected 1", data_sram_req); end
        tests++; if (data_sram_wr !== 1'b0 || data_sram_wstrb !== 4'h0) begin fails++; $display("FAIL blk_load_wr: got wr=%b wstrb=%h expected 0/0", data_sram_wr, data_sram_wstrb); end
        data_sram_addr_ok = 1'b1;
        #1;
        tests++; if (EXE_to_MEM_valid !== 1'b1) begin fails++; $display("FAIL blk_ack_mem_valid: got %b expected 1", EXE_to_MEM_valid); end
        tests++; if (EXE_allow_in !== 1'b0) begin fails++; $display("FAIL blk_ack_allow_in: got %b expected 0", EXE_allow_in); end
        // addr_ok is left high: a repeated request would show up as req=1.
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            tests++; if (data_sram_req !== 1'b0) begin fails++; $display("FAIL blk_no_reissue cyc%0d: got %b expected 0", k, data_sram_req); end
            tests++; if (EXE_to_MEM_valid !== 1'b1) begin fails++; $display("FAIL blk_hold_valid cyc%0d: got %b expected 1", k, EXE_to_MEM_valid); end
            tests++; if (EXE_to_MEM_bus !== {3'b010, 1'b1, 1'b0, 5'd9, 32'h2010, 32'h300}) begin fails++; $display("FAIL blk_hold_bus cyc%0d: got %h expected %h", k, EXE_to_MEM_bus, {3'b010, 1'b1, 1'b0, 5'd9, 32'h2010, 32'h300}); end
            tests++; if (EXE_allow_in !== 1'b0) begin fails++; $display("FAIL blk_allow_in cyc%0d: got %b expected 0", k, EXE_allow_in); end
        end
        data_sram_addr_ok = 1'b0;
        MEM_allow_in      = 1'b1;
        #1;
        tests++; if (EXE_allow_in !== 1'b1) begin fails++; $display("FAIL blk_release_allow_in: got %b expected 1", EXE_allow_in); end
        @(posedge clk); #1;
        tests++; if (EXE_to_MEM_valid !== 1'b0) begin fails++; $display("FAIL blk_drain_valid: got %b expected 0", EXE_to_MEM_valid); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a [0:2];
        logic [31:0] b [0:2];
        logic [31:0] r [0:2];
        a[0] = 32'd1;   b[0] = 32'd2;   r[0] = 32'd3;
        a[1] = 32'd10;  b[1] = 32'd20;  r[1] = 32'd30;
        a[2] = 32'd100; b[2] = 32'd200; r[2] = 32'd300;
        MEM_allow_in      = 1'b1;
        data_sram_addr_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ID_to_EXE_bus   = mk_bus(3'b001, 1'b1, 1'b0, 1'b0, 32'd0, 5'(i + 1),
                                     12'h001, b[i], a[i], 32'h400 + 32'(4 * i));
            ID_to_EXE_valid = 1'b1;
            @(posedge clk); #1;
            tests++; if (EXE_to_MEM_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid %0d: got %b expected 1", i, EXE_to_MEM_valid); end
            tests++; if (EXE_to_MEM_bus[63:32] !== r[i]) begin fails++; $display("FAIL b2b_result %0d: got %h expected %h", i, EXE_to_MEM_bus[63:32], r[i]); end
            tests++; if (EXE_allow_in !== 1'b1) begin fails++; $display("FAIL b2b_allow_in %0d: got %b expected 1", i, EXE_allow_in); end
        end
        ID_to_EXE_valid = 1'b0;
        @(posedge clk); #1;
        tests++; if (EXE_to_MEM_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain_valid: got %b expected 0", EXE_to_MEM_valid); end
    endtask

    task automatic test_bypass;
        MEM_allow_in      = 1'b1;
        data_sram_addr_ok = 1'b1;
        ID_to_EXE_bus     = mk_bus(3'b010, 1'b1, 1'b0, 1'b1, 32'd0, 5'd7,
                                   12'h001, 32'h8, 32'h4000, 32'h500);
        ID_to_EXE_valid   = 1'b1;
        @(posedge clk); #1;
        tests++; if (EXE_to_BY_bus[39:35] !== 5'd7) begin fails++; $display("FAIL by_load_addr: got %0d expected 7", EXE_to_BY_bus[39:35]); end
        tests++; if (EXE_to_BY_bus[2:0] !== 3'b011) begin fails++; $display("FAIL by_load_flags: got %b expected 011", EXE_to_BY_bus[2:0]); end
        tests++; if (EXE_to_MEM_valid !== 1'b1) begin fails++; $display("FAIL by_load_mem_valid: got %b expected 1", EXE_to_MEM_valid); end
        ID_to_EXE_bus     = mk_bus(3'b001, 1'b1, 1'b0, 1'b0, 32'd0, 5'd3,
                                   12'h001, 32'd3, 32'd2, 32'h504);
        @(posedge clk); #1;
        ID_to_EXE_valid   = 1'b0;
        data_sram_addr_ok = 1'b0;
        tests++; if (EXE_to_BY_bus !== {5'd3, 32'd5, 3'b111}) begin fails++; $display("FAIL by_add_bus: got %h expected %h", EXE_to_BY_bus, {5'd3, 32'd5, 3'b111}); end
        tests++; if (data_sram_req !== 1'b0) begin fails++; $display("FAIL by_add_req: got %b expected 0", data_sram_req); end
        @(posedge clk); #1;
        tests++; if (EXE_to_BY_bus[1] !== 1'b0) begin fails++; $display("FAIL by_drain_valid: got %b expected 0", EXE_to_BY_bus[1]); end
    endtask

    task automatic test_reset_mid_op;
        MEM_allow_in      = 1'b1;
        data_sram_addr_ok = 1'b0;
        ID_to_EXE_bus     = mk_bus(3'b100, 1'b0, 1'b1, 1'b1, 32'h0BAD_F00D, 5'd0,
                                   12'h001, 32'd8, 32'h3000, 32'h600);
        ID_to_EXE_valid   = 1'b1;
        @(posedge clk); #1;
        ID_to_EXE_valid   = 1'b0;
        tests++; if (data_sram_req !== 1'b1) begin fails++; $display("FAIL rmid_req_before: got %b expected 1", data_sram_req); end
        #2 reset = 1'b0;
        #1;
        tests++; if (data_sram_req !== 1'b0) begin fails++; $display("FAIL rmid_req_async: got %b expected 0", data_sram_req); end
        tests++; if (EXE_allow_in !== 1'b1) begin fails++; $display("FAIL rmid_allow_in_async: got %b expected 1", EXE_allow_in); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        tests++; if (EXE_allow_in !== 1'b1) begin fails++; $display("FAIL rmid_allow_in_after: got %b expected 1", EXE_allow_in); end
        tests++; if (EXE_to_MEM_valid !== 1'b0) begin fails++; $display("FAIL rmid_mem_valid_after: got %b expected 0", EXE_to_MEM_valid); end
        tests++; if (data_sram_req !== 1'b0) begin fails++; $display("FAIL rmid_req_after: got %b expected 0", data_sram_req); end
    endtask

    initial begin
        tests             = 0;
        fails             = 0;
        reset             = 1'b0;
        ID_to_EXE_valid   = 1'b0;
        ID_to_EXE_bus     = '0;
        MEM_allow_in      = 1'b1;
        data_sram_addr_ok = 1'b0;
        test_reset;
        test_alu;
        test_store_late;
        test_blocked_by_mem;
        test_back_to_back;
        test_bypass;
        test_reset_mid_op;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
Fourth pipeline stage. It sits directly downstream of the decode/issue stage and consumes its 153-bit issue bus. It latches the issued instruction, evaluates the one-hot ALU operation, and issues the data-RAM address/write request through a req/addr_ok handshake, holding the instruction until the request is accepted. It then forwards the result to the MEM stage and drives the EXE bypass/wake-up fields back to issue.

Parameters:
ID_TO_EXE_BUS_WD, 153, width of the incoming issue bus.
EXE_TO_MEM_BUS_WD, 74, width of the outgoing MEM bus.
EXE_TO_BY_BUS_WD, 40, width of the bypass bus to issue.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (0 = reset)
ID_to_EXE_bus  in  153  {stage_valid[2:0], rf_w_en, rf_w_data_sel, ram_wd, ram_we, ram_en, ram_wdata[31:0], w_addr[4:0], alu_op[11:0], src2[31:0], src1[31:0], inst_PC[31:0]}, MSB first
ID_to_EXE_valid  in  1  issue bus valid
EXE_allow_in  out  1  stage can accept a new instruction this cycle
MEM_allow_in  in  1  MEM stage can accept
EXE_to_MEM_valid  out  1  EXE_to_MEM_bus valid
EXE_to_MEM_bus  out  74  {stage_valid[2:0], rf_w_en, rf_w_data_sel, w_addr[4:0], alu_result[31:0], inst_PC[31:0]}
EXE_to_BY_bus  out  40  {w_addr[4:0], alu_result[31:0], data_valid, EXE_valid, rf_w_en}
data_sram_req  out  1  memory request
data_sram_wr  out  1  1 = store
data_sram_wstrb  out  4  byte strobes
data_sram_addr  out  32  = alu_result
data_sram_wdata  out  32  store data
data_sram_addr_ok  in  1  request accepted this cycle

Behaviour:
- Reset (asynchronous, while reset=0): EXE_valid=0, the bus register is cleared, FSM=IDLE. All outputs are 0 except EXE_allow_in=1. Reset asserted mid-request drops the request immediately; no completion is owed.
- Accept: EXE_allow_in = ~EXE_valid | (ready_go & MEM_allow_in). On the clk edge with EXE_allow_in, EXE_valid<=ID_to_EXE_valid, and the bus register loads only if ID_to_EXE_valid=1.
- ALU (combinational, one-hot alu_op, bits 0..11): add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - Shifts use src2 as the value and src1[4:0] as the amount.
  - lui passes src2.
  - All arithmetic wraps modulo 2^32.
  - alu_op all-zero yields 0.
- FSM states:
  - IDLE: no memory op pending.
  - REQ: data_sram_req=1 and held stable.
  - DONE: request accepted, waiting for MEM_allow_in.
- FSM transitions:
  - Entering with a valid instruction where ram_en=1 → REQ.
  - REQ & addr_ok → DONE, or → IDLE if the hand-off happens in the same cycle.
  - DONE & MEM_allow_in → IDLE, or → REQ if the next accepted instruction is a memory op.
  - A request is never issued twice for one instruction.
- data_sram_req = EXE_valid & ram_en & (state==REQ). While req=1 and addr_ok=0, addr, wdata, wr and wstrb hold stable.
- data_sram_wr = ram_we. data_sram_wstrb = ram_we ? 4'hF : 4'h0. data_sram_wdata = ram_wdata.
- ready_go = ~ram_en | (state==REQ & addr_ok) | (state==DONE).
- Latency: non-memory ops take 1 cycle. Memory ops take ≥1 cycle, ending on the addr_ok cycle.
- EXE_to_MEM_valid = EXE_valid & ready_go. Bus fields pass through unchanged except alu_result.
- Bypass outputs:
  - data_valid = stage_valid[0] (result final in EXE); loads carry 0 so issue stalls.
  - EXE_valid and rf_w_en are reported as-is; w_addr=0 is reported unchanged, and issue filters it.
- Back-pressure: with MEM_allow_in=0 and ready_go=1, hold all outputs and EXE_allow_in=0.
- Simultaneous events: hand-off to MEM and accept from issue in the same edge are a normal back-to-back flow with no bubble.

Test Plan:
- Reset mid-op: assert reset low while data_sram_req=1 → req falls with no clk edge; after release, EXE_allow_in=1 and EXE_to_MEM_valid=0.
- ALU sweep: src1=5, src2=32'hFFFF_FFF0 for each op → add=32'hFFFF_FFF5, sltu=1, slt=0, sra=32'hFFFF_FFFF, lui=32'hFFFF_FFF0; each valid 1 cycle later with MEM_allow_in=1.
- Store with a late addr_ok: ram_en=ram_we=1, src1=0x1000, src2=4, ram_wdata=0xDEADBEEF, addr_ok delayed 3 cycles:
  - req=1, addr=0x1004, wstrb=F, held stable for all 3 wait cycles;
  - EXE_allow_in=0 throughout;
  - EXE_to_MEM_valid rises on the addr_ok cycle.
- Accepted request blocked by MEM: addr_ok in cycle 1, MEM_allow_in=0 for 2 cycles → req=0 after acceptance (exactly one request); EXE_to_MEM_valid stays 1 and the bus is held.
- Back-to-back: three add instructions issued on consecutive cycles with MEM_allow_in=1 → three consecutive EXE_to_MEM_valid pulses, with no gaps and results in order.
- Bypass: load (stage_valid=3'b010, w_addr=7) → EXE_to_BY_bus reports addr 7, data_valid=0, valid=1, w_en=1; add (3'b001) → data_valid=1 with the result.
